// File: rtl/csr_machine.sv
// csr_machine: machine-mode CSR file for the execute stage.
// Decodes the implemented machine CSRs and performs CSRRW/CSRRS/CSRRC
// read-modify-write on them. Also holds the 64-bit cycle/instret counters,
// the trap entry / MRET state updates and interrupt pending logic.
module csr_machine #(
  parameter int              XLEN        = 32,
  parameter int              HARTID      = 0,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            csr_en,
  input  logic [1:0]      csr_op,
  input  logic [4:0]      rs1,
  input  logic [11:0]     addr,
  input  logic [XLEN-1:0] data_w,
  output logic [XLEN-1:0] data_r,
  output logic            illegal,
  input  logic            instret,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_val,
  input  logic            mret,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic            irq_ext,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] mepc_o,
  output logic            irq_pending
);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  localparam logic [1:0]      MXL       = (XLEN == 32) ? 2'd1 : 2'd2;
  localparam logic [XLEN-1:0] MISA_VAL  = (XLEN'(MXL) << (XLEN - 2)) | XLEN'(9'h100);
  localparam logic [XLEN-1:0] MIE_MASK  = XLEN'(12'h888);

  // Architectural state
  logic            mstatusMie_q, mstatusMie_d;
  logic            mstatusMpie_q, mstatusMpie_d;
  logic [XLEN-1:0] mieReg_q, mieReg_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic            inhibitCy_q, inhibitCy_d;
  logic            inhibitIr_q, inhibitIr_d;
  logic [63:0]     mcycle_q, mcycle_d;
  logic [63:0]     minstret_q, minstret_d;

  logic [XLEN-1:0] mstatusVal;
  logic [XLEN-1:0] mipVal;
  logic [XLEN-1:0] readVal;
  logic            implemented;
  logic            writeAttempt;
  logic            doWrite;
  logic [XLEN-1:0] newVal;
  logic [XLEN-1:0] tvecBase;
  logic            unusedCause;

  assign mstatusVal = XLEN'({2'b11, 3'b000, mstatusMpie_q, 3'b000, mstatusMie_q, 3'b000});
  assign mipVal     = XLEN'({irq_ext, 3'b000, irq_timer, 3'b000, irq_sw, 3'b000});

  // Address decode: old value of the addressed CSR and whether it exists
  always_comb begin
    readVal     = '0;
    implemented = 1'b0;
    case (addr)
      CSR_MSTATUS:       begin implemented = 1'b1; readVal = mstatusVal; end
      CSR_MISA:          begin implemented = 1'b1; readVal = MISA_VAL; end
      CSR_MIE:           begin implemented = 1'b1; readVal = mieReg_q; end
      CSR_MTVEC:         begin implemented = 1'b1; readVal = mtvec_q; end
      CSR_MCOUNTINHIBIT: begin implemented = 1'b1; readVal = XLEN'({inhibitIr_q, 1'b0, inhibitCy_q}); end
      CSR_MSCRATCH:      begin implemented = 1'b1; readVal = mscratch_q; end
      CSR_MEPC:          begin implemented = 1'b1; readVal = mepc_q; end
      CSR_MCAUSE:        begin implemented = 1'b1; readVal = mcause_q; end
      CSR_MTVAL:         begin implemented = 1'b1; readVal = mtval_q; end
      CSR_MIP:           begin implemented = 1'b1; readVal = mipVal; end
      CSR_MCYCLE,
      CSR_CYCLE:         begin implemented = 1'b1; readVal = mcycle_q[XLEN-1:0]; end
      CSR_MINSTRET,
      CSR_INSTRET:       begin implemented = 1'b1; readVal = minstret_q[XLEN-1:0]; end
      CSR_MCYCLEH,
      CSR_CYCLEH: begin
        if (XLEN == 32) begin
          implemented = 1'b1;
          readVal     = XLEN'(mcycle_q[63:32]);
        end
      end
      CSR_MINSTRETH,
      CSR_INSTRETH: begin
        if (XLEN == 32) begin
          implemented = 1'b1;
          readVal     = XLEN'(minstret_q[63:32]);
        end
      end
      CSR_MVENDORID,
      CSR_MARCHID,
      CSR_MIMPID:        begin implemented = 1'b1; readVal = '0; end
      CSR_MHARTID:       begin implemented = 1'b1; readVal = XLEN'(HARTID); end
      default: ;
    endcase
  end

  assign writeAttempt = csr_en && ((csr_op == OP_RW) || (rs1 != 5'd0));
  assign illegal      = csr_en && (!implemented || (writeAttempt && (addr[11:10] == 2'b11)));
  assign doWrite      = writeAttempt && !illegal && (csr_op != OP_NONE);
  assign data_r       = readVal;

  // Read-modify-write operand before the per-register WARL mask
  always_comb begin
    newVal = readVal;
    case (csr_op)
      OP_RW:   newVal = data_w;
      OP_RS:   newVal = readVal | data_w;
      OP_RC:   newVal = readVal & ~data_w;
      default: newVal = readVal;
    endcase
  end

  // Next state of the non-counter CSRs; trap beats mret beats a CSR write
  always_comb begin
    mstatusMie_d  = mstatusMie_q;
    mstatusMpie_d = mstatusMpie_q;
    mieReg_d      = mieReg_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    inhibitCy_d   = inhibitCy_q;
    inhibitIr_d   = inhibitIr_q;
    if (doWrite) begin
      case (addr)
        CSR_MSTATUS: begin
          mstatusMie_d  = newVal[3];
          mstatusMpie_d = newVal[7];
        end
        CSR_MIE:      mieReg_d   = newVal & MIE_MASK;
        CSR_MTVEC:    mtvec_d    = newVal & ~XLEN'(2);
        CSR_MSCRATCH: mscratch_d = newVal;
        CSR_MEPC:     mepc_d     = newVal & ~XLEN'(1);
        CSR_MCAUSE:   mcause_d   = newVal;
        CSR_MTVAL:    mtval_d    = newVal;
        CSR_MCOUNTINHIBIT: begin
          inhibitCy_d = newVal[0];
          inhibitIr_d = newVal[2];
        end
        default: ;
      endcase
    end
    if (trap) begin
      mepc_d        = trap_pc & ~XLEN'(1);
      mcause_d      = trap_cause;
      mtval_d       = trap_val;
      mstatusMpie_d = mstatusMie_q;
      mstatusMie_d  = 1'b0;
    end else if (mret) begin
      mstatusMie_d  = mstatusMpie_q;
      mstatusMpie_d = 1'b1;
    end
  end

  // Counter next state: a write to either half replaces it and skips the increment
  always_comb begin
    mcycle_d   = mcycle_q;
    minstret_d = minstret_q;
    if (doWrite && ((addr == CSR_MCYCLE) || (addr == CSR_MCYCLEH))) begin
      if (addr == CSR_MCYCLE) begin
        if (XLEN == 32) mcycle_d[31:0] = newVal[31:0];
        else            mcycle_d       = 64'(newVal);
      end else begin
        mcycle_d[63:32] = newVal[31:0];
      end
    end else if (!inhibitCy_q) begin
      mcycle_d = mcycle_q + 64'd1;
    end
    if (doWrite && ((addr == CSR_MINSTRET) || (addr == CSR_MINSTRETH))) begin
      if (addr == CSR_MINSTRET) begin
        if (XLEN == 32) minstret_d[31:0] = newVal[31:0];
        else            minstret_d       = 64'(newVal);
      end else begin
        minstret_d[63:32] = newVal[31:0];
      end
    end else if (instret && !inhibitIr_q) begin
      minstret_d = minstret_q + 64'd1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mstatusMie_q  <= 1'b0;
      mstatusMpie_q <= 1'b0;
      mieReg_q      <= '0;
      mtvec_q       <= MTVEC_RESET;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      inhibitCy_q   <= 1'b0;
      inhibitIr_q   <= 1'b0;
      mcycle_q      <= '0;
      minstret_q    <= '0;
    end else begin
      mstatusMie_q  <= mstatusMie_d;
      mstatusMpie_q <= mstatusMpie_d;
      mieReg_q      <= mieReg_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      inhibitCy_q   <= inhibitCy_d;
      inhibitIr_q   <= inhibitIr_d;
      mcycle_q      <= mcycle_d;
      minstret_q    <= minstret_d;
    end
  end

  // Handler target: vectored mode only offsets for interrupts
  always_comb begin
    tvecBase    = mtvec_q & ~XLEN'(3);
    trap_vector = tvecBase;
    if ((mtvec_q[1:0] == 2'b01) && trap_cause[XLEN-1]) begin
      trap_vector = tvecBase + XLEN'({trap_cause[5:0], 2'b00});
    end
  end

  // Only the MSB and low cause bits select the vector slot
  assign unusedCause = ^trap_cause[XLEN-2:6];

  assign mepc_o      = mepc_q;
  assign irq_pending = mstatusMie_q & (|(mipVal & mieReg_q));

endmodule

// File: tb/tb_csr_machine.sv
// tb_csr_machine: scoreboard bench for csr_machine (XLEN 32).
// Expected values are queued when stimulus is driven and popped when the
// outputs are sampled on the falling edge.
module tb_csr_machine;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        csr_en = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic [4:0]  rs1 = 5'd0;
  logic [11:0] addr = 12'h000;
  logic [31:0] data_w = 32'd0;
  logic [31:0] data_r;
  logic        illegal;
  logic        instret = 1'b0;
  logic        trap = 1'b0;
  logic [31:0] trap_cause = 32'd0;
  logic [31:0] trap_pc = 32'd0;
  logic [31:0] trap_val = 32'd0;
  logic        mret = 1'b0;
  logic        irq_sw = 1'b0;
  logic        irq_timer = 1'b0;
  logic        irq_ext = 1'b0;
  logic [31:0] trap_vector;
  logic [31:0] mepc_o;
  logic        irq_pending;

  int totalChecks = 0;
  int badChecks = 0;

  logic [31:0] expQ[$];
  string       tagQ[$];

  csr_machine #(
    .XLEN(32),
    .HARTID(7),
    .MTVEC_RESET(32'h0000_0100)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .csr_en(csr_en),
    .csr_op(csr_op),
    .rs1(rs1),
    .addr(addr),
    .data_w(data_w),
    .data_r(data_r),
    .illegal(illegal),
    .instret(instret),
    .trap(trap),
    .trap_cause(trap_cause),
    .trap_pc(trap_pc),
    .trap_val(trap_val),
    .mret(mret),
    .irq_sw(irq_sw),
    .irq_timer(irq_timer),
    .irq_ext(irq_ext),
    .trap_vector(trap_vector),
    .mepc_o(mepc_o),
    .irq_pending(irq_pending)
  );

  // 10 ns clock
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic pushExpect(input string tag, input logic [31:0] value);
    tagQ.push_back(tag);
    expQ.push_back(value);
  endtask

  task automatic popCompare(input logic [31:0] observed);
    string       tag;
    logic [31:0] expected;
    if (expQ.size() == 0) begin
      checkOutput("scoreboard-depth", 32'(expQ.size()), 32'd1);
    end else begin
      tag      = tagQ.pop_front();
      expected = expQ.pop_front();
      checkOutput(tag, observed, expected);
    end
  endtask

  // One CSR access lasting one clock: drive at posedge+1, sample at negedge
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [4:0] r,
                               input logic [11:0] a, input logic [31:0] wd,
                               input logic [31:0] expData, input logic expIll, input bit cmpData);
    csr_en = 1'b1;
    csr_op = op;
    rs1    = r;
    addr   = a;
    data_w = wd;
    if (cmpData) pushExpect({tag, "/data"}, expData);
    pushExpect({tag, "/illegal"}, 32'(expIll));
    @(negedge clock);
    if (cmpData) popCompare(data_r);
    popCompare(32'(illegal));
    @(posedge clock);
    #1;
    csr_en = 1'b0;
    csr_op = 2'b00;
    rs1    = 5'd0;
    addr   = 12'h000;
    data_w = 32'd0;
  endtask

  task automatic readCsr(input string tag, input logic [11:0] a, input logic [31:0] expected);
    applyStimulus(tag, OP_RS, 5'd0, a, 32'd0, expected, 1'b0, 1'b1);
  endtask

  // Main sequence
  initial begin
    #2;
    pushExpect("rst-irq_pending", 32'd0);
    pushExpect("rst-mepc_o", 32'd0);
    @(negedge clock);
    popCompare(32'(irq_pending));
    popCompare(mepc_o);
    @(posedge clock);
    #1;
    readCsr("rst-mstatus", 12'h300, 32'h0000_1800);
    readCsr("rst-mtvec", 12'h305, 32'h0000_0100);
    reset_n = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    readCsr("mcycle-at-10", 12'hB00, 32'd10);

    readCsr("misa", 12'h301, 32'h4000_0100);
    readCsr("mhartid", 12'hF14, 32'd7);
    applyStimulus("mhartid-rs1-5", OP_RS, 5'd5, 12'hF14, 32'd1, 32'd0, 1'b1, 1'b0);
    readCsr("mhartid-after", 12'hF14, 32'd7);
    applyStimulus("unimpl-addr", OP_RS, 5'd0, 12'h7C0, 32'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus("cycle-ro-write", OP_RW, 5'd0, 12'hC00, 32'd0, 32'd0, 1'b1, 1'b0);
    readCsr("mvendorid", 12'hF11, 32'd0);

    applyStimulus("mscratch-rw", OP_RW, 5'd1, 12'h340, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
    applyStimulus("mscratch-rs", OP_RS, 5'd2, 12'h340, 32'h0000_000F, 32'hDEAD_BEEF, 1'b0, 1'b1);
    applyStimulus("mscratch-rc", OP_RC, 5'd3, 12'h340, 32'h0000_00F0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    readCsr("mscratch-final", 12'h340, 32'hDEAD_BE0F);

    applyStimulus("mstatus-rw-ones", OP_RW, 5'd1, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0, 1'b1);
    readCsr("mstatus-warl", 12'h300, 32'h0000_1888);
    applyStimulus("mstatus-rw-mie", OP_RW, 5'd1, 12'h300, 32'h0000_0008, 32'h0000_1888, 1'b0, 1'b1);
    readCsr("mstatus-mie-only", 12'h300, 32'h0000_1808);
    applyStimulus("mie-rw-ones", OP_RW, 5'd1, 12'h304, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    readCsr("mie-warl", 12'h304, 32'h0000_0888);
    applyStimulus("mie-rw-timer", OP_RW, 5'd1, 12'h304, 32'h0000_0080, 32'h0000_0888, 1'b0, 1'b1);
    applyStimulus("mtvec-rw", OP_RW, 5'd1, 12'h305, 32'h0000_1003, 32'h0000_0100, 1'b0, 1'b1);
    readCsr("mtvec-warl", 12'h305, 32'h0000_1001);

    pushExpect("irq-idle", 32'd0);
    @(negedge clock);
    popCompare(32'(irq_pending));
    @(posedge clock);
    #1;
    irq_timer = 1'b1;
    readCsr("mip-timer", 12'h344, 32'h0000_0080);
    trap_cause = 32'h0000_0002;
    pushExpect("irq-pending-timer", 32'd1);
    pushExpect("trapvec-sync", 32'h0000_1000);
    @(negedge clock);
    popCompare(32'(irq_pending));
    popCompare(trap_vector);
    @(posedge clock);
    #1;

    trap       = 1'b1;
    trap_cause = 32'h8000_0007;
    trap_pc    = 32'h0000_2003;
    trap_val   = 32'h0000_0055;
    pushExpect("trapvec-vectored", 32'h0000_101C);
    @(negedge clock);
    popCompare(trap_vector);
    @(posedge clock);
    #1;
    trap = 1'b0;
    pushExpect("mepc_o-after-trap", 32'h0000_2002);
    pushExpect("irq-masked-after-trap", 32'd0);
    @(negedge clock);
    popCompare(mepc_o);
    popCompare(32'(irq_pending));
    @(posedge clock);
    #1;
    readCsr("mstatus-after-trap", 12'h300, 32'h0000_1880);
    readCsr("mcause-after-trap", 12'h342, 32'h8000_0007);
    readCsr("mtval-after-trap", 12'h343, 32'h0000_0055);

    mret = 1'b1;
    @(posedge clock);
    #1;
    mret = 1'b0;
    readCsr("mstatus-after-mret", 12'h300, 32'h0000_1888);
    pushExpect("irq-after-mret", 32'd1);
    @(negedge clock);
    popCompare(32'(irq_pending));
    @(posedge clock);
    #1;

    trap       = 1'b1;
    trap_cause = 32'h0000_000B;
    trap_pc    = 32'h0000_3000;
    trap_val   = 32'd0;
    applyStimulus("mepc-rw-vs-trap", OP_RW, 5'd1, 12'h341, 32'h0000_0040, 32'h0000_2002, 1'b0, 1'b1);
    trap = 1'b0;
    readCsr("mepc-trap-wins", 12'h341, 32'h0000_3000);
    readCsr("mcause-trap-wins", 12'h342, 32'h0000_000B);
    mret = 1'b1;
    applyStimulus("mstatus-rw-vs-mret", OP_RW, 5'd1, 12'h300, 32'd0, 32'h0000_1880, 1'b0, 1'b1);
    mret = 1'b0;
    readCsr("mstatus-mret-wins", 12'h300, 32'h0000_1888);

    applyStimulus("mcycleh-rw-zero", OP_RW, 5'd1, 12'hB80, 32'd0, 32'd0, 1'b0, 1'b1);
    applyStimulus("mcycle-rw-max", OP_RW, 5'd1, 12'hB00, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    readCsr("mcycle-written", 12'hB00, 32'hFFFF_FFFF);
    readCsr("mcycleh-carry", 12'hB80, 32'd1);
    readCsr("mcycle-after-carry", 12'hB00, 32'd1);

    instret = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    instret = 1'b0;
    readCsr("minstret-3", 12'hB02, 32'd3);
    readCsr("instret-mirror", 12'hC02, 32'd3);
    instret = 1'b1;
    applyStimulus("minstret-rw", OP_RW, 5'd1, 12'hB02, 32'h0000_0100, 32'd3, 1'b0, 1'b1);
    instret = 1'b0;
    readCsr("minstret-no-inc", 12'hB02, 32'h0000_0100);

    applyStimulus("mcountinhibit-rw", OP_RW, 5'd1, 12'h320, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    readCsr("mcountinhibit-warl", 12'h320, 32'h0000_0005);
    applyStimulus("mcycle-rw-1234", OP_RW, 5'd1, 12'hB00, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
    instret = 1'b1;
    readCsr("mcycle-frozen-1", 12'hB00, 32'h0000_1234);
    readCsr("mcycle-frozen-2", 12'hB00, 32'h0000_1234);
    readCsr("minstret-frozen", 12'hB02, 32'h0000_0100);
    instret = 1'b0;

    applyStimulus("mcycleh-rw-max", OP_RW, 5'd1, 12'hB80, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    applyStimulus("mcycle-rw-max2", OP_RW, 5'd1, 12'hB00, 32'hFFFF_FFFF, 32'h0000_1234, 1'b0, 1'b1);
    applyStimulus("mcountinhibit-clr", OP_RW, 5'd1, 12'h320, 32'd0, 32'h0000_0005, 1'b0, 1'b1);
    readCsr("mcycle-pre-wrap", 12'hB00, 32'hFFFF_FFFF);
    readCsr("mcycleh-wrapped", 12'hB80, 32'd0);
    readCsr("mcycle-wrapped", 12'hB00, 32'd1);

    csr_en = 1'b1;
    csr_op = OP_RW;
    rs1    = 5'd1;
    addr   = 12'h340;
    data_w = 32'h0000_1111;
    #2;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    csr_en  = 1'b0;
    csr_op  = 2'b00;
    rs1     = 5'd0;
    addr    = 12'h000;
    data_w  = 32'd0;
    reset_n = 1'b1;
    readCsr("mscratch-reset-abort", 12'h340, 32'd0);
    readCsr("mstatus-after-reset", 12'h300, 32'h0000_1800);

    checkOutput("scoreboard-drained", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #100000;
    badChecks++;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
